link_on_ctrl: RTL and testbench

Link-state controller on the Receiver Board that sequences link bring-up and tear-down from the filtered LINK_ON indication.
- Qualifies the filtered level with a consecutive-sample counter before declaring the link up.
- Declares loss after a sustained drop, then enforces a hold-off before re-arming.
- Drives the receive-path enable and a saturating loss counter for status readout.
- Runs in the 25 MHz receiver clock domain, directly downstream of the LINK_ON input filter.

---
 rtl/link_on_ctrl.sv | 150 +++++++++++++++
 tb/tb_link_on_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/link_on_ctrl.sv
// Link-state controller: qualifies the filtered LINK_ON level and sequences DOWN/WAIT/UP/HOLD.
// Define LINK_ON_CTRL_RX_GATE_EARLY_EN to drop rx_en on the first low sample seen in UP.
module link_on_ctrl #(
   parameter int ON_CNT   = 25000,
   parameter int OFF_CNT  = 250,
   parameter int HOLD_CNT = 2500,
   parameter int CNT_W    = 16,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             link_on,
   input  logic             force_down,
   output logic             link_up,
   output logic             rx_en,
   output logic             link_lost,
   output logic [ERR_W-1:0] loss_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_DOWN = 2'd0,
      S_WAIT = 2'd1,
      S_UP   = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ON_LIM   = CNT_W'(ON_CNT);
   localparam logic [CNT_W-1:0] OFF_LIM  = CNT_W'(OFF_CNT);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CNT);
   localparam logic [ERR_W-1:0] LOSS_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             link_up_d, rx_en_d, link_lost_d;
   logic [ERR_W-1:0] loss_cnt_d;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign state   = state_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d     = state_q;
      cnt_d       = cnt_q;
      link_up_d   = link_up;
      rx_en_d     = rx_en;
      link_lost_d = 1'b0;
      loss_cnt_d  = loss_cnt;

      case (state_q)
         S_DOWN: begin
            cnt_d     = '0;
            link_up_d = 1'b0;
            rx_en_d   = 1'b0;
            if (link_on && !force_down) begin
               if (ON_CNT == 1) begin
                  state_d   = S_UP;
                  link_up_d = 1'b1;
                  rx_en_d   = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end

         S_WAIT: begin
            if (force_down || !link_on) begin
               state_d = S_DOWN;
               cnt_d   = '0;
            end else if (cnt_inc == ON_LIM) begin
               state_d   = S_UP;
               cnt_d     = '0;
               link_up_d = 1'b1;
               rx_en_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         S_UP: begin
            // In UP the shared counter tracks consecutive low samples.
            if (force_down) begin
               state_d   = S_HOLD;
               cnt_d     = '0;
               link_up_d = 1'b0;
               rx_en_d   = 1'b0;
            end else if (!link_on) begin
               if (cnt_inc == OFF_LIM) begin
                  state_d     = S_HOLD;
                  cnt_d       = '0;
                  link_up_d   = 1'b0;
                  rx_en_d     = 1'b0;
                  link_lost_d = 1'b1;
                  if (loss_cnt != LOSS_MAX) loss_cnt_d = loss_cnt + ERR_W'(1);
               end else begin
                  cnt_d = cnt_inc;
`ifdef LINK_ON_CTRL_RX_GATE_EARLY_EN
                  rx_en_d = 1'b0;
`else
                  rx_en_d = 1'b1;
`endif
               end
            end else begin
               cnt_d   = '0;
               rx_en_d = 1'b1;
            end
         end

         S_HOLD: begin
            // force_down keeps restarting the hold-off so it always runs HOLD_CNT clean cycles.
            if (force_down) begin
               cnt_d = '0;
            end else if (cnt_inc == HOLD_LIM) begin
               state_d = S_DOWN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            state_d   = S_DOWN;
            cnt_d     = '0;
            link_up_d = 1'b0;
            rx_en_d   = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_DOWN;
         cnt_q     <= '0;
         link_up   <= 1'b0;
         rx_en     <= 1'b0;
         link_lost <= 1'b0;
         loss_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         link_up   <= link_up_d;
         rx_en     <= rx_en_d;
         link_lost <= link_lost_d;
         loss_cnt  <= loss_cnt_d;
      end
   end

endmodule

// File: tb/tb_link_on_ctrl.sv
// Self-checking bench for link_on_ctrl (ON_CNT=8, OFF_CNT=3, HOLD_CNT=5): per-cycle model compare plus directed literals.
module tb_link_on_ctrl;

   localparam int ON   = 8;
   localparam int OFF  = 3;
   localparam int HOLD = 5;
   localparam int ERRW = 8;
   localparam int LMAX = (1 << ERRW) - 1;
`ifdef LINK_ON_CTRL_RX_GATE_EARLY_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic            clk, rst_n, link_on, force_down;
   logic            link_up, rx_en, link_lost;
   logic [ERRW-1:0] loss_cnt;
   logic [1:0]      state;

   int n_checks = 0;
   int n_errors = 0;

   link_on_ctrl #(
      .ON_CNT(ON), .OFF_CNT(OFF), .HOLD_CNT(HOLD), .CNT_W(16), .ERR_W(ERRW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .link_on(link_on), .force_down(force_down),
      .link_up(link_up), .rx_en(rx_en), .link_lost(link_lost),
      .loss_cnt(loss_cnt), .state(state)
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: phase plus run length of the condition the phase is counting.
   int m_phase, m_run, m_loss;
   bit m_up, m_rx, m_lost;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_run <= 0; m_loss <= 0;
         m_up <= 0; m_rx <= 0; m_lost <= 0;
      end else begin
         int ph, run, loss;
         bit up, rx, lost;
         ph = m_phase; run = m_run; loss = m_loss;
         up = m_up; rx = m_rx; lost = 0;
         if (m_phase == 0) begin
            run = 0; up = 0; rx = 0;
            if (link_on && !force_down) begin
               if (ON == 1) begin ph = 2; up = 1; rx = 1; end
               else begin ph = 1; run = 1; end
            end
         end else if (m_phase == 1) begin
            if (force_down || !link_on) begin ph = 0; run = 0; end
            else if (m_run + 1 == ON) begin ph = 2; run = 0; up = 1; rx = 1; end
            else run = m_run + 1;
         end else if (m_phase == 2) begin
            if (force_down) begin ph = 3; run = 0; up = 0; rx = 0; end
            else if (!link_on) begin
               if (m_run + 1 == OFF) begin
                  ph = 3; run = 0; up = 0; rx = 0; lost = 1;
                  loss = (m_loss + 1 > LMAX) ? LMAX : m_loss + 1;
               end else begin
                  run = m_run + 1; rx = !EARLY;
               end
            end else begin run = 0; rx = 1; end
         end else begin
            if (force_down) run = 0;
            else if (m_run + 1 == HOLD) begin ph = 0; run = 0; end
            else run = m_run + 1;
         end
         m_phase <= ph; m_run <= run; m_loss <= loss;
         m_up <= up; m_rx <= rx; m_lost <= lost;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_state", state, m_phase);
         check("cmp_link_up", link_up, m_up);
         check("cmp_rx_en", rx_en, m_rx);
         check("cmp_link_lost", link_lost, m_lost);
         check("cmp_loss_cnt", loss_cnt, m_loss);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 0; link_on = 0; force_down = 0;
      tick(2);
      rst_n = 1;
   endtask

   task automatic async_reset_check(input string tag);
      @(posedge clk);
      #5 rst_n = 0;
      #1;
      check({tag, "_state"}, state, 0);
      check({tag, "_link_up"}, link_up, 0);
      check({tag, "_rx_en"}, rx_en, 0);
      check({tag, "_link_lost"}, link_lost, 0);
      check({tag, "_loss_cnt"}, loss_cnt, 0);
      @(negedge clk) rst_n = 1;
   endtask

   initial begin
      clk = 0; rst_n = 0; link_on = 0; force_down = 0;
      tick(2);
      check("rst_state", state, 0);
      check("rst_link_up", link_up, 0);
      check("rst_rx_en", rx_en, 0);
      check("rst_link_lost", link_lost, 0);
      check("rst_loss_cnt", loss_cnt, 0);
      rst_n = 1;
      tick(1);

      // Qualification: UP on the edge of the 8th high sample.
      link_on = 1;
      tick(1); check("t1_wait", state, 1);
      tick(6); check("t1_still_wait", state, 1); check("t1_not_up", link_up, 0);
      tick(1); check("t1_up_state", state, 2); check("t1_link_up", link_up, 1); check("t1_rx_en", rx_en, 1);
      tick(4); check("t1_stays_up", link_up, 1);

      // Glitch after 7 highs restarts qualification.
      do_reset();
      link_on = 1; tick(7); check("t2_wait7", state, 1);
      link_on = 0; tick(1); check("t2_back_down", state, 0);
      link_on = 1; tick(7); check("t2_requal_not_up", link_up, 0);
      tick(1); check("t2_requal_up", state, 2);

      // Two low samples in UP: no loss.
      link_on = 0;
      tick(1); check("t3_rx_low1", rx_en, !EARLY); check("t3_up1", link_up, 1);
      tick(1); check("t3_rx_low2", rx_en, !EARLY); check("t3_up2", link_up, 1);
      link_on = 1;
      tick(1); check("t3_rx_back", rx_en, 1); check("t3_state", state, 2);

      // Three lows: loss, hold-off, re-qualification.
      link_on = 0;
      tick(2); check("t4_still_up", state, 2);
      tick(1); check("t4_hold", state, 3); check("t4_lost", link_lost, 1);
      check("t4_loss_cnt", loss_cnt, 1); check("t4_link_down", link_up, 0);
      link_on = 1;
      tick(1); check("t4_pulse_one_cycle", link_lost, 0);
      tick(3); check("t4_hold4", state, 3);
      tick(1); check("t4_down", state, 0);
      tick(7); check("t4_requal_wait", state, 1);
      tick(1); check("t4_requal_up", state, 2);

      // force_down in UP: HOLD without a loss event.
      force_down = 1;
      tick(1); check("t5_hold", state, 3); check("t5_link_up", link_up, 0);
      check("t5_no_lost", link_lost, 0); check("t5_loss_same", loss_cnt, 1);
      tick(3); check("t5_hold_forced", state, 3);
      force_down = 0;
      tick(4); check("t5_hold_after4", state, 3);
      tick(1); check("t5_down", state, 0);
      tick(8); check("t5_requal", state, 2);

      // Toggling every cycle never qualifies.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         link_on = ~link_on;
         tick(1);
      end
      check("toggle_never_up", link_up, 0);

      // 256 losses: saturation at 255 with the pulse still firing.
      do_reset();
      link_on = 1; tick(8);
      for (int i = 1; i <= 256; i++) begin
         link_on = 0; tick(3);
         check("sat_lost_pulse", link_lost, 1);
         check("sat_loss_cnt", loss_cnt, (i > LMAX) ? LMAX : i);
         link_on = 1; tick(13);
      end
      check("sat_final", loss_cnt, 255);
      check("sat_back_up", state, 2);

      // Asynchronous reset mid-HOLD then mid-WAIT.
      link_on = 0; tick(3); check("mid_hold_entry", state, 3);
      tick(2);
      async_reset_check("rst_hold");
      link_on = 1; tick(3); check("mid_wait_entry", state, 1);
      async_reset_check("rst_wait");
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
